// File: rtl/e_mult_div.sv
// e_mult_div: execute-stage multiply/divide unit with architectural HI/LO.
// Operands are latched when an operation starts. The product or quotient is
// computed from the latched operands and written to HI/LO on the last busy
// cycle. This matches the multi-cycle latency seen by the rest of the pipeline.
module e_mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_op_e           op_in;
    md_op_e           op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             is_md_op;
    logic             idle;
    logic             accept;
    logic             finish;
    logic [CNT_W-1:0] load_val;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      b_mag_safe;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      b_u_safe;
    logic [31:0]      uq;
    logic [31:0]      ur;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;

    assign op_in    = md_op_e'(md_op);
    assign idle     = (count_q == '0);
    assign md_busy  = ~idle;
    assign md_hi    = hi_q;
    assign md_lo    = lo_q;
    assign md_stall = md_busy | (md_start & is_md_op);

    // Request decode: which ops occupy the unit, and when a start is taken.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        is_md_op = 1'b0;
        load_val = MULT_LOAD;
        unique case (op_in)
            OP_MULT, OP_MULTU: is_md_op = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_md_op = 1'b1;
                load_val = DIV_LOAD;
            end
            default: ;
        endcase
        accept = md_start & is_md_op & idle;
        finish = (count_q == CNT_ONE);
    end

    // Arithmetic datapaths on the latched operands.
    always_comb begin
        prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        // Signed divide runs on magnitudes. 0x80000000 / -1 then wraps to
        // 0x80000000 with remainder 0 instead of overflowing.
        a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        b_u_safe   = (b_q == 32'd0) ? 32'd1 : b_q;
        uq         = a_q / b_u_safe;
        ur         = a_q % b_u_safe;
    end

    // Select the completion result; a zero divisor leaves HI/LO untouched.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                res_wr = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV: begin
                res_wr = (b_q != 32'd0);
                res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = a_q[31] ? (32'd0 - r_mag) : r_mag;
            end
            OP_DIVU: begin
                res_wr = (b_q != 32'd0);
                res_lo = uq;
                res_hi = ur;
            end
            default: ;
        endcase
    end

    // Busy counter, operand latch and HI/LO update.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            count_q <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                a_q     <= md_a;
                b_q     <= md_b;
                count_q <= load_val;
            end else if (!idle) begin
                count_q <= count_q - CNT_ONE;
            end

            if (finish) begin
                if (res_wr) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else if (md_start && idle) begin
                if (op_in == OP_MTHI) hi_q <= md_a;
                if (op_in == OP_MTLO) lo_q <= md_a;
            end
        end
    end

endmodule

// File: tb/tb_e_mult_div.sv
// tb_e_mult_div: directed vectors for e_mult_div. Expected HI/LO values and
// busy lengths go into a scoreboard queue. A monitor pops each entry when
// md_busy falls and compares the result.
module tb_e_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    e_mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_hi    (md_hi),
        .md_lo    (md_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request for a cycle; check md_stall while it is presented.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_stall);
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        #1;
        check({name, "_stall_at_T"}, {31'd0, md_stall}, {31'd0, exp_stall});
        @(posedge clk); #1;
        md_start = 1'b0;
        md_op    = 3'd0;
        md_a     = 32'hDEAD_BEEF;
        md_b     = 32'hDEAD_BEEF;
    endtask

    task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40 && md_busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (md_busy !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: md_busy still %b after 40 cycles, want 0", name, md_busy);
        end
        // Let the monitor see the falling edge of md_busy before moving on.
        @(posedge clk); #1;
    endtask

    // Monitor: count busy cycles and score the result when md_busy falls normally.
    initial begin
        int  busy_len;
        bit  busy_prev;
        busy_len  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (md_busy === 1'b1) begin
                busy_len++;
            end else begin
                if (busy_prev && reset === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got busy_len %0d, want no operation", busy_len);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check({e.name, "_hi"}, md_hi, e.hi);
                        check({e.name, "_lo"}, md_lo, e.lo);
                        check({e.name, "_busy_len"}, 32'(busy_len), 32'(e.len));
                    end
                end
                busy_len = 0;
            end
            busy_prev = (md_busy === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        md_start = 1'b0;
        md_op    = 3'd0;
        md_a     = 32'd0;
        md_b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_hi", md_hi, 32'd0);
        check("reset_lo", md_lo, 32'd0);
        check("reset_busy", {31'd0, md_busy}, 32'd0);
        check("reset_stall", {31'd0, md_stall}, 32'd0);

        // mult -3 * 7 = -21
        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        issue("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
        check("mult_busy_T1", {31'd0, md_busy}, 32'd1);
        check("mult_hi_old_during_busy", md_hi, 32'd0);
        wait_idle("mult");

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        push("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle("multu");

        // div -7 / 2: quotient -3, remainder -1
        push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle("div_neg");

        // divu 7 / 0: HI/LO unchanged
        push("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("divu_by0", 3'd4, 32'd7, 32'd0, 1'b1);
        wait_idle("divu_by0");

        // div overflow case
        push("div_ovf", 32'd0, 32'h8000_0000, 10);
        issue("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle("div_ovf");

        // mthi while idle: no stall, no busy, visible next cycle
        issue("mthi", 3'd5, 32'h0000_1234, 32'd0, 1'b0);
        check("mthi_hi", md_hi, 32'h0000_1234);
        check("mthi_lo_kept", md_lo, 32'h8000_0000);
        check("mthi_busy", {31'd0, md_busy}, 32'd0);

        // mult 3*4; mtlo and a div start during busy must be ignored
        push("mult_small", 32'd0, 32'd12, 5);
        issue("mult_small", 3'd1, 32'd3, 32'd4, 1'b1);
        issue("mtlo_busy", 3'd6, 32'h0000_AAAA, 32'd0, 1'b1);
        check("mtlo_ignored_lo", md_lo, 32'h8000_0000);
        issue("div_busy", 3'd3, 32'd100, 32'd5, 1'b1);
        wait_idle("mult_small");

        // divu 100/3 aborted by reset in busy cycle 4
        issue("divu_abort", 3'd4, 32'd100, 32'd3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before_reset", {31'd0, md_busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        check("abort_hi", md_hi, 32'd0);
        check("abort_lo", md_lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_abort_hi", md_hi, 32'd0);
        check("post_abort_lo", md_lo, 32'd0);
        check("post_abort_busy", {31'd0, md_busy}, 32'd0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
